fpu_job_arbiter: RTL and testbench
==================================

Name: fpu_job_arbiter

Overview:
Shares a single FPU datapath between NUM_REQ hardware requesters, such as DMA engines or accelerator lanes, alongside the host interface. It accepts one job at a time using round-robin selection and latches the job's operands, operation and format. It then rings the FPU doorbell, waits for fpu_ready (bounded by a timeout), and returns the result and exception flags tagged with the requester ID. It sits between the requesters and the FPU operand/command inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), requester ID width (derived, not overridable)
TIMEOUT_CYC, 255, maximum cycles in WAIT before aborting the job (1..65535)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester job request
req_ready  out  NUM_REQ  per-requester accept; a job transfers on valid&ready
req_operation  in  2*NUM_REQ  flattened op per requester (0 add, 1 sub, 2 mul, 3 fused mul-add)
req_format  in  2*NUM_REQ  flattened FP format per requester
req_operand_a  in  32*NUM_REQ  flattened operand A
req_operand_b  in  32*NUM_REQ  flattened operand B
req_operand_c  in  32*NUM_REQ  flattened operand C (used only for op 3)
rsp_valid  out  1  one-cycle response strobe
rsp_id  out  ID_W  requester index of the response
rsp_result  out  32  FPU result
rsp_flags  out  4  {inexact, underflow, overflow, invalid}
rsp_timeout  out  1  job aborted by timeout
busy  out  1  arbiter is not in IDLE
fpu_doorbell  out  1  one-cycle start pulse to the FPU
fpu_operation  out  2  latched operation
fpu_fused_m_a  out  1  high when fpu_operation==3
fpu_format  out  2  latched format
fpu_operand_a/b/c  out  32 each  latched operands
fpu_ready  in  1  FPU completion
fpu_output  in  32  FPU result
fpu_invalid_op_flag, fpu_overflow_flag, fpu_underflow_flag, fpu_inexact_flag  in  1 each  FPU flags

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer = NUM_REQ-1 (requester 0 wins first), timeout counter 0.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - req_ready is combinational and one-hot for the round-robin winner, searching from pointer+1 with wrap-around.
  - req_ready is all-zero when no req_valid is asserted.
  - On handshake: latch op, format and operands into holding registers; pointer <= winner; go to ISSUE.
- ISSUE: fpu_doorbell = 1 for exactly one cycle; clear the counter; go to WAIT.
- WAIT:
  - Counter increments every cycle.
  - fpu_ready high: capture fpu_output and the four flags; go to RESP.
  - Counter == TIMEOUT_CYC-1 with fpu_ready low: result = 0, flags = 0, rsp_timeout = 1; go to RESP.
  - fpu_ready and timeout in the same cycle: fpu_ready wins and rsp_timeout = 0.
- RESP: rsp_valid = 1 for one cycle, with rsp_id/result/flags/timeout valid in that cycle. There is no backpressure. Next state is IDLE.
- rsp_* hold their last values outside RESP; only rsp_valid returns to 0.
- fpu_ready is sampled only in WAIT; it is ignored in IDLE, ISSUE and RESP.
- fpu_operand_*, fpu_operation and fpu_format stay stable from ISSUE until the next accept. They are never changed while in WAIT.
- Latency: handshake in cycle N, doorbell in N+1, earliest fpu_ready in N+2, rsp_valid in N+3. Minimum turnaround is 4 cycles per job.
- A requester may deassert req_valid before acceptance without error. Acceptance is only the cycle in which valid&ready are both high.
- Fairness: the just-served requester has the lowest priority in the next arbitration.
- Asynchronous reset mid-job drops the job silently, with no response. The FPU is expected to be reset by the same reset_n.
- busy = (state != IDLE).

Decomposition:
- Package fpu_arb_pkg holds:
  - the state encoding (IDLE, ISSUE, WAIT, RESP);
  - operation codes OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_FMA=3;
  - the flag bit positions FLAG_INVALID=0, FLAG_OVERFLOW=1, FLAG_UNDERFLOW=2, FLAG_INEXACT=3.
- One sub-module, rr_arbiter (parameter N): combinational one-hot grant from the request vector and the pointer, plus a registered pointer update on an enable input. It is reusable across the design.

Test Plan:
- Single job: req_valid[1]=1, op 2, A=0x40000000, B=0x40400000; FPU model asserts ready 5 cycles after doorbell with 0x40C00000. Expect: one doorbell pulse; rsp_valid with rsp_id=1, rsp_result=0x40C00000, rsp_flags=0, rsp_timeout=0; exactly 1 cycle after ready.
- Contention: all 4 req_valid held high for 8 jobs. Expect grant order 0,1,2,3,0,1,2,3; each rsp_id matches; no grant to a requester whose valid is low.
- Timeout: TIMEOUT_CYC=16, FPU never ready. Expect rsp_valid 16 cycles after WAIT entry with rsp_timeout=1, result 0, flags 0; the next queued job proceeds normally.
- Ready/timeout coincidence and spurious ready: fpu_ready asserted in the same cycle the counter hits TIMEOUT_CYC-1 -> rsp_timeout=0 and the captured result is returned. fpu_ready high during IDLE/ISSUE -> ignored, with no response generated.
- Flags and FMA: op 3 with the FPU returning invalid|inexact (0b1001). Expect fpu_fused_m_a=1 throughout and rsp_flags=4'b1001.
- Reset mid-WAIT: assert reset_n low for 1 cycle. Expect all outputs 0, no rsp_valid, pointer restored so requester 0 wins the next arbitration.

Source files
------------

// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the FPU job arbiter.
package fpu_arb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned FMT_W  = 2;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [OP_W-1:0] OP_ADD = 2'd0;
    localparam logic [OP_W-1:0] OP_SUB = 2'd1;
    localparam logic [OP_W-1:0] OP_MUL = 2'd2;
    localparam logic [OP_W-1:0] OP_FMA = 2'd3;

    localparam int unsigned FLAG_INVALID   = 0;
    localparam int unsigned FLAG_OVERFLOW  = 1;
    localparam int unsigned FLAG_UNDERFLOW = 2;
    localparam int unsigned FLAG_INEXACT   = 3;

    typedef struct packed {
        logic [OP_W-1:0]   operation;
        logic [FMT_W-1:0]  format;
        logic [DATA_W-1:0] operand_a;
        logic [DATA_W-1:0] operand_b;
        logic [DATA_W-1:0] operand_c;
    } job_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from pointer+1,
// pointer moves to the winner when update_en is high.
module rr_arbiter #(
    parameter  int unsigned N     = 4,
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    input  logic             update_en,
    output logic [N-1:0]     grant_c,
    output logic [PTR_W-1:0] grant_idx_c
);

    logic [PTR_W-1:0] ptr_q;
    logic             found;
    int unsigned      idx;

    // First requester after the pointer, with wrap-around, wins.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        found       = 1'b0;
        idx         = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[PTR_W'(idx)]) begin
                found                  = 1'b1;
                grant_c[PTR_W'(idx)]   = 1'b1;
                grant_idx_c            = PTR_W'(idx);
            end
        end
    end

    // Pointer resets to N-1 so requester 0 is served first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= PTR_W'(N - 1);
        end else if (update_en) begin
            ptr_q <= grant_idx_c;
        end
    end

endmodule

// File: rtl/fpu_job_arbiter.sv
// Shares one FPU between NUM_REQ requesters: accept, ring doorbell, wait
// (with timeout), return tagged result.
module fpu_job_arbiter
    import fpu_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ     = 4,
    parameter  int unsigned TIMEOUT_CYC = 255,
    localparam int unsigned ID_W        = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [OP_W*NUM_REQ-1:0]   req_operation,
    input  logic [FMT_W*NUM_REQ-1:0]  req_format,
    input  logic [DATA_W*NUM_REQ-1:0] req_operand_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_operand_b,
    input  logic [DATA_W*NUM_REQ-1:0] req_operand_c,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_result,
    output logic [FLAG_W-1:0]         rsp_flags,
    output logic                      rsp_timeout,
    output logic                      busy,
    output logic                      fpu_doorbell,
    output logic [OP_W-1:0]           fpu_operation,
    output logic                      fpu_fused_m_a,
    output logic [FMT_W-1:0]          fpu_format,
    output logic [DATA_W-1:0]         fpu_operand_a,
    output logic [DATA_W-1:0]         fpu_operand_b,
    output logic [DATA_W-1:0]         fpu_operand_c,
    input  logic                      fpu_ready,
    input  logic [DATA_W-1:0]         fpu_output,
    input  logic                      fpu_invalid_op_flag,
    input  logic                      fpu_overflow_flag,
    input  logic                      fpu_underflow_flag,
    input  logic                      fpu_inexact_flag
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  grant_c;
    logic [ID_W-1:0]     win_idx_c;
    logic                accept_c;
    logic                timeout_c;
    job_t                job_sel_c;
    job_t                job_q;
    logic [ID_W-1:0]     id_q;
    logic [FLAG_W-1:0]   flags_c;

    logic                fused_q;
    logic                doorbell_q;
    logic                rsp_valid_q;
    logic                busy_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [DATA_W-1:0]   rsp_result_q;
    logic [FLAG_W-1:0]   rsp_flags_q;
    logic                rsp_timeout_q;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req_valid),
        .update_en   (accept_c),
        .grant_c     (grant_c),
        .grant_idx_c (win_idx_c)
    );

    // Grants are only offered while idle.
    assign req_ready = (state_q == ST_IDLE) ? grant_c : '0;
    assign accept_c  = (state_q == ST_IDLE) && (|req_valid);
    assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Pick the winning requester's slice out of the flattened buses.
    always_comb begin
        job_sel_c           = '0;
        job_sel_c.operation = OP_W'(req_operation >> (OP_W * 32'(win_idx_c)));
        job_sel_c.format    = FMT_W'(req_format >> (FMT_W * 32'(win_idx_c)));
        job_sel_c.operand_a = DATA_W'(req_operand_a >> (DATA_W * 32'(win_idx_c)));
        job_sel_c.operand_b = DATA_W'(req_operand_b >> (DATA_W * 32'(win_idx_c)));
        job_sel_c.operand_c = DATA_W'(req_operand_c >> (DATA_W * 32'(win_idx_c)));
    end

    // Pack FPU exception flags into response order.
    always_comb begin
        flags_c                 = '0;
        flags_c[FLAG_INVALID]   = fpu_invalid_op_flag;
        flags_c[FLAG_OVERFLOW]  = fpu_overflow_flag;
        flags_c[FLAG_UNDERFLOW] = fpu_underflow_flag;
        flags_c[FLAG_INEXACT]   = fpu_inexact_flag;
    end

    // State and wait counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; fpu_ready outranks the timeout in WAIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (fpu_ready || timeout_c) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, job holding registers and response capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            job_q         <= '0;
            id_q          <= '0;
            fused_q       <= 1'b0;
            doorbell_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            rsp_id_q      <= '0;
            rsp_result_q  <= '0;
            rsp_flags_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            doorbell_q  <= (state_d == ST_ISSUE);
            rsp_valid_q <= (state_d == ST_RESP);
            busy_q      <= (state_d != ST_IDLE);
            if (accept_c) begin
                job_q   <= job_sel_c;
                id_q    <= win_idx_c;
                fused_q <= (job_sel_c.operation == OP_FMA);
            end
            if (state_q == ST_WAIT) begin
                if (fpu_ready) begin
                    rsp_id_q      <= id_q;
                    rsp_result_q  <= fpu_output;
                    rsp_flags_q   <= flags_c;
                    rsp_timeout_q <= 1'b0;
                end else if (timeout_c) begin
                    rsp_id_q      <= id_q;
                    rsp_result_q  <= '0;
                    rsp_flags_q   <= '0;
                    rsp_timeout_q <= 1'b1;
                end
            end
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_result    = rsp_result_q;
    assign rsp_flags     = rsp_flags_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign busy          = busy_q;
    assign fpu_doorbell  = doorbell_q;
    assign fpu_operation = job_q.operation;
    assign fpu_fused_m_a = fused_q;
    assign fpu_format    = job_q.format;
    assign fpu_operand_a = job_q.operand_a;
    assign fpu_operand_b = job_q.operand_b;
    assign fpu_operand_c = job_q.operand_c;

endmodule

// File: tb/tb_fpu_job_arbiter.sv
// Directed bench for fpu_job_arbiter with hand-computed expectations.
module tb_fpu_job_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned TO = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [2*NR-1:0]   req_operation;
    logic [2*NR-1:0]   req_format;
    logic [32*NR-1:0]  req_operand_a;
    logic [32*NR-1:0]  req_operand_b;
    logic [32*NR-1:0]  req_operand_c;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [31:0]       rsp_result;
    logic [3:0]        rsp_flags;
    logic              rsp_timeout;
    logic              busy;
    logic              fpu_doorbell;
    logic [1:0]        fpu_operation;
    logic              fpu_fused_m_a;
    logic [1:0]        fpu_format;
    logic [31:0]       fpu_operand_a;
    logic [31:0]       fpu_operand_b;
    logic [31:0]       fpu_operand_c;
    logic              fpu_ready;
    logic [31:0]       fpu_output;
    logic              fpu_invalid_op_flag;
    logic              fpu_overflow_flag;
    logic              fpu_underflow_flag;
    logic              fpu_inexact_flag;

    int n_checks = 0;
    int n_fail   = 0;
    int db_cnt   = 0;
    int rsp_cnt  = 0;
    int rc;

    fpu_job_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_operation       (req_operation),
        .req_format          (req_format),
        .req_operand_a       (req_operand_a),
        .req_operand_b       (req_operand_b),
        .req_operand_c       (req_operand_c),
        .rsp_valid           (rsp_valid),
        .rsp_id              (rsp_id),
        .rsp_result          (rsp_result),
        .rsp_flags           (rsp_flags),
        .rsp_timeout         (rsp_timeout),
        .busy                (busy),
        .fpu_doorbell        (fpu_doorbell),
        .fpu_operation       (fpu_operation),
        .fpu_fused_m_a       (fpu_fused_m_a),
        .fpu_format          (fpu_format),
        .fpu_operand_a       (fpu_operand_a),
        .fpu_operand_b       (fpu_operand_b),
        .fpu_operand_c       (fpu_operand_c),
        .fpu_ready           (fpu_ready),
        .fpu_output          (fpu_output),
        .fpu_invalid_op_flag (fpu_invalid_op_flag),
        .fpu_overflow_flag   (fpu_overflow_flag),
        .fpu_underflow_flag  (fpu_underflow_flag),
        .fpu_inexact_flag    (fpu_inexact_flag)
    );

    always #5 clk = ~clk;

    // Count doorbell and response pulses mid-cycle.
    always @(negedge clk) begin
        if (fpu_doorbell) db_cnt++;
        if (rsp_valid)    rsp_cnt++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_job(input int r, input logic [1:0] op, input logic [1:0] fmt,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        req_operation[2*r +: 2]  = op;
        req_format[2*r +: 2]     = fmt;
        req_operand_a[32*r +: 32] = a;
        req_operand_b[32*r +: 32] = b;
        req_operand_c[32*r +: 32] = c;
    endtask

    task automatic set_fpu(input logic rdy, input logic [31:0] out, input logic [3:0] fl);
        fpu_ready  = rdy;
        fpu_output = out;
        {fpu_inexact_flag, fpu_underflow_flag, fpu_overflow_flag, fpu_invalid_op_flag} = fl;
    endtask

    initial begin
        reset_n       = 1'b0;
        req_valid     = '0;
        req_operation = '0;
        req_format    = '0;
        req_operand_a = '0;
        req_operand_b = '0;
        req_operand_c = '0;
        set_fpu(1'b0, 32'h0, 4'h0);

        // Reset state
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_doorbell", 32'(fpu_doorbell), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_operand_a", fpu_operand_a, 32'd0);
        chk("rst_fused", 32'(fpu_fused_m_a), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick();

        // Contention: all requesters valid, expect 0,1,2,3,0,1,2,3
        for (int r = 0; r < 4; r++) begin
            set_job(r, 2'(r), 2'd1, 32'h1000 + 32'(r), 32'h2000 + 32'(r), 32'h3000 + 32'(r));
        end
        req_valid = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            #1;
            chk("cont_ready", 32'(req_ready), 32'd1 << (j % 4));
            tick();
            chk("cont_doorbell", 32'(fpu_doorbell), 32'd1);
            chk("cont_operand_a", fpu_operand_a, 32'h1000 + 32'(j % 4));
            chk("cont_fused", 32'(fpu_fused_m_a), ((j % 4) == 3) ? 32'd1 : 32'd0);
            tick();
            set_fpu(1'b1, 32'hA000 + 32'(j), 4'h0);
            tick();
            set_fpu(1'b0, 32'h0, 4'h0);
            chk("cont_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("cont_rsp_id", 32'(rsp_id), 32'(j % 4));
            chk("cont_rsp_result", rsp_result, 32'hA000 + 32'(j));
            tick();
        end
        req_valid = '0;
        chk("cont_doorbells", 32'(db_cnt), 32'd8);
        chk("cont_responses", 32'(rsp_cnt), 32'd8);

        // Withdrawn request and spurious fpu_ready in IDLE
        req_valid = 4'b1010;
        #1;
        chk("subset_ready", 32'(req_ready), 32'b0010);
        req_valid = 4'b0000;
        #1;
        chk("withdraw_ready", 32'(req_ready), 32'd0);
        set_fpu(1'b1, 32'hDEAD, 4'hF);
        tick(2);
        set_fpu(1'b0, 32'h0, 4'h0);
        chk("idle_ready_busy", 32'(busy), 32'd0);
        chk("idle_ready_rsp", 32'(rsp_cnt), 32'd8);

        // Single job on requester 1, ready 5 cycles after doorbell
        set_job(1, 2'd2, 2'd0, 32'h40000000, 32'h40400000, 32'h0);
        req_valid = 4'b0010;
        #1;
        chk("single_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0000;
        chk("single_doorbell", 32'(fpu_doorbell), 32'd1);
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_op", 32'(fpu_operation), 32'd2);
        chk("single_a", fpu_operand_a, 32'h40000000);
        chk("single_b", fpu_operand_b, 32'h40400000);
        chk("single_fused", 32'(fpu_fused_m_a), 32'd0);
        chk("single_ready_busy", 32'(req_ready), 32'd0);
        set_fpu(1'b1, 32'hDEADBEEF, 4'hF);
        tick();
        set_fpu(1'b0, 32'h0, 4'h0);
        chk("single_db_pulse", 32'(fpu_doorbell), 32'd0);
        tick();
        chk("issue_ready_ignored", 32'(rsp_valid), 32'd0);
        tick(3);
        set_fpu(1'b1, 32'h40C00000, 4'h0);
        chk("single_pre_rsp", 32'(rsp_valid), 32'd0);
        tick();
        set_fpu(1'b0, 32'h0, 4'h0);
        chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("single_rsp_id", 32'(rsp_id), 32'd1);
        chk("single_rsp_result", rsp_result, 32'h40C00000);
        chk("single_rsp_flags", 32'(rsp_flags), 32'd0);
        chk("single_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("single_a_stable", fpu_operand_a, 32'h40000000);
        tick();
        chk("single_rsp_end", 32'(rsp_valid), 32'd0);
        chk("single_rsp_hold", rsp_result, 32'h40C00000);
        chk("single_idle", 32'(busy), 32'd0);
        chk("single_doorbells", 32'(db_cnt), 32'd9);

        // Timeout on requester 2, requester 3 queued behind it
        set_job(2, 2'd0, 2'd1, 32'h11111111, 32'h22222222, 32'h0);
        set_job(3, 2'd1, 2'd1, 32'h33333333, 32'h44444444, 32'h0);
        req_valid = 4'b1100;
        #1;
        chk("to_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b1000;
        tick();
        tick(15);
        chk("to_not_yet", 32'(rsp_valid), 32'd0);
        chk("to_busy", 32'(busy), 32'd1);
        chk("to_a_stable", fpu_operand_a, 32'h11111111);
        tick();
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
        chk("to_rsp_result", rsp_result, 32'd0);
        chk("to_rsp_flags", 32'(rsp_flags), 32'd0);
        chk("to_rsp_id", 32'(rsp_id), 32'd2);
        tick();
        #1;
        chk("next_ready", 32'(req_ready), 32'b1000);
        tick();
        req_valid = 4'b0000;
        chk("next_a", fpu_operand_a, 32'h33333333);
        chk("next_op", 32'(fpu_operation), 32'd1);
        tick();
        set_fpu(1'b1, 32'h55555555, 4'b0100);
        tick();
        set_fpu(1'b0, 32'h0, 4'h0);
        chk("next_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("next_rsp_id", 32'(rsp_id), 32'd3);
        chk("next_rsp_result", rsp_result, 32'h55555555);
        chk("next_rsp_flags", 32'(rsp_flags), 32'b0100);
        chk("next_rsp_timeout", 32'(rsp_timeout), 32'd0);
        tick();

        // FMA with ready coinciding with the last WAIT cycle
        set_job(0, 2'd3, 2'd2, 32'h3F800000, 32'h40000000, 32'h40400000);
        req_valid = 4'b0001;
        #1;
        chk("fma_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0000;
        chk("fma_fused_issue", 32'(fpu_fused_m_a), 32'd1);
        chk("fma_op", 32'(fpu_operation), 32'd3);
        chk("fma_fmt", 32'(fpu_format), 32'd2);
        chk("fma_c", fpu_operand_c, 32'h40400000);
        tick();
        tick(15);
        set_fpu(1'b1, 32'h40E00000, 4'b1001);
        chk("fma_fused_wait", 32'(fpu_fused_m_a), 32'd1);
        chk("fma_no_early_rsp", 32'(rsp_valid), 32'd0);
        tick();
        set_fpu(1'b0, 32'h0, 4'h0);
        chk("coin_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("coin_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("coin_rsp_result", rsp_result, 32'h40E00000);
        chk("coin_rsp_flags", 32'(rsp_flags), 32'b1001);
        chk("coin_rsp_id", 32'(rsp_id), 32'd0);
        chk("fma_fused_resp", 32'(fpu_fused_m_a), 32'd1);
        tick();
        chk("coin_rsp_end", 32'(rsp_valid), 32'd0);

        // Reset in the middle of WAIT drops the job
        set_job(1, 2'd0, 2'd0, 32'h12345678, 32'h9ABCDEF0, 32'h0);
        req_valid = 4'b0010;
        #1;
        chk("mid_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0000;
        tick();
        tick(3);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_doorbell", 32'(fpu_doorbell), 32'd0);
        chk("mid_rst_result", rsp_result, 32'd0);
        chk("mid_rst_flags", 32'(rsp_flags), 32'd0);
        chk("mid_rst_a", fpu_operand_a, 32'd0);
        chk("mid_rst_op", 32'(fpu_operation), 32'd0);
        chk("mid_rst_fused", 32'(fpu_fused_m_a), 32'd0);
        rc = rsp_cnt;
        tick();
        reset_n = 1'b1;
        tick(20);
        chk("mid_no_rsp", 32'(rsp_cnt), 32'(rc));
        chk("mid_idle", 32'(busy), 32'd0);
        req_valid = 4'b1111;
        #1;
        chk("mid_ptr_restored", 32'(req_ready), 32'b0001);
        req_valid = 4'b0000;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
